// File: rtl/collision_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : collision_pkg
//  Description : Shared types and helpers for the frame-based collision
//                detector: scan FSM state encoding, default coordinate width
//                and an index-width helper (clog2 with a floor of 1).
//  Revision    : 1.0 - initial release
// ============================================================================
package collision_pkg;

    // Coordinate width used when the instantiating design does not override it.
    localparam int DEFAULT_COORD_W = 10;

    // Scan controller states, explicitly encoded in two bits.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to index n items. Never returns less than 1, so a
    // single-channel build still has a legal one-bit index.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : collision_pkg
`default_nettype wire

// File: rtl/aabb_overlap.sv
`default_nettype none
// ============================================================================
//  Module      : aabb_overlap
//  Description : Combinational axis-aligned bounding-box overlap test.
//                Box A (A_W x A_H) at (i_a_x, i_a_y) and box B (B_W x B_H)
//                at (i_b_x, i_b_y), both given by their top-left corner.
//                Boxes whose edges merely touch do not overlap.
//  Ports       : i_a_x, i_a_y  - box A top-left corner
//                i_b_x, i_b_y  - box B top-left corner
//                o_overlap     - 1 when the two boxes share at least one pixel
//  Revision    : 1.0 - initial release
// ============================================================================
module aabb_overlap #(
    parameter int COORD_W = 10,
    parameter int A_W     = 8,
    parameter int A_H     = 8,
    parameter int B_W     = 16,
    parameter int B_H     = 16
) (
    input  logic [COORD_W-1:0] i_a_x,
    input  logic [COORD_W-1:0] i_a_y,
    input  logic [COORD_W-1:0] i_b_x,
    input  logic [COORD_W-1:0] i_b_y,
    output logic               o_overlap
);

    // One extra bit of headroom: a box sitting at the far screen edge has
    // its right/bottom edge beyond the coordinate range. Without the extra
    // bit that sum would wrap to a small value and produce false hits (or
    // miss real ones) near the edge.
    localparam int c_ext_w = COORD_W + 1;

    localparam logic [c_ext_w-1:0] c_a_w = c_ext_w'(A_W);
    localparam logic [c_ext_w-1:0] c_a_h = c_ext_w'(A_H);
    localparam logic [c_ext_w-1:0] c_b_w = c_ext_w'(B_W);
    localparam logic [c_ext_w-1:0] c_b_h = c_ext_w'(B_H);

    logic [c_ext_w-1:0] w_ax;
    logic [c_ext_w-1:0] w_ay;
    logic [c_ext_w-1:0] w_bx;
    logic [c_ext_w-1:0] w_by;
    logic [c_ext_w-1:0] w_ax_end;
    logic [c_ext_w-1:0] w_ay_end;
    logic [c_ext_w-1:0] w_bx_end;
    logic [c_ext_w-1:0] w_by_end;

    assign w_ax     = {1'b0, i_a_x};
    assign w_ay     = {1'b0, i_a_y};
    assign w_bx     = {1'b0, i_b_x};
    assign w_by     = {1'b0, i_b_y};

    // Exclusive end coordinates (first pixel outside the box).
    assign w_ax_end = w_ax + c_a_w;
    assign w_ay_end = w_ay + c_a_h;
    assign w_bx_end = w_bx + c_b_w;
    assign w_by_end = w_by + c_b_h;

    // Strict comparisons make touching edges a non-overlap.
    assign o_overlap = (w_ax < w_bx_end) & (w_bx < w_ax_end) &
                       (w_ay < w_by_end) & (w_by < w_ay_end);

endmodule : aabb_overlap
`default_nettype wire

// File: rtl/collision_detector.sv
`default_nettype none
// ============================================================================
//  Module      : collision_detector
//  Description : Sequential per-frame crash check. A start pulse snapshots
//                the plane box and NUM_OBJ obstacle boxes, one obstacle is
//                tested per clock, and the result is published in a single
//                DONE cycle. game_over is sticky until clear or reset.
//  Ports       : clk        - system clock
//                reset      - asynchronous active-high reset
//                start      - begin a frame check (accepted only in IDLE)
//                clear      - abort any scan, clear crash and game_over
//                plane_x/y  - plane top-left corner
//                obj_x/y    - obstacle corners, channel i at [i*COORD_W +: COORD_W]
//                obj_valid  - per-channel enable
//                busy       - high while scanning
//                done       - one-cycle pulse when a scan completes
//                crash      - hit result of the last completed scan
//                crash_idx  - lowest hit channel of the last completed scan
//                game_over  - sticky crash flag
//  Options     : CRASH_GRACE_EN - when defined, a grace counter loaded with
//                GRACE_FRAMES on clear/reset suppresses game_over for that
//                many completed scans.
//  Revision    : 1.0 - initial release
// ============================================================================
module collision_detector
    import collision_pkg::*;
#(
    parameter int NUM_OBJ      = 4,
    parameter int COORD_W      = DEFAULT_COORD_W,
    parameter int PLANE_W      = 8,
    parameter int PLANE_H      = 8,
    parameter int OBJ_W        = 16,
    parameter int OBJ_H        = 16,
    parameter int GRACE_FRAMES = 30
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           clear,
    input  logic [COORD_W-1:0]             plane_x,
    input  logic [COORD_W-1:0]             plane_y,
    input  logic [NUM_OBJ*COORD_W-1:0]     obj_x,
    input  logic [NUM_OBJ*COORD_W-1:0]     obj_y,
    input  logic [NUM_OBJ-1:0]             obj_valid,
    output logic                           busy,
    output logic                           done,
    output logic                           crash,
    output logic [idx_width(NUM_OBJ)-1:0]  crash_idx,
    output logic                           game_over
);

    localparam int                 c_idx_w = idx_width(NUM_OBJ);
    localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(NUM_OBJ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;

    // Frame snapshot: the scan only ever looks at these, so the position
    // generators are free to move objects while a check is running.
    logic [COORD_W-1:0] r_plane_x;
    logic [COORD_W-1:0] r_plane_y;
    logic [COORD_W-1:0] r_obj_x [NUM_OBJ];
    logic [COORD_W-1:0] r_obj_y [NUM_OBJ];
    logic [NUM_OBJ-1:0] r_obj_valid;

    logic [c_idx_w-1:0] r_idx;
    logic               r_hit;
    logic [c_idx_w-1:0] r_hit_idx;

    logic               w_overlap;
    logic               w_take_hit;
    logic               w_allow_game_over;

    // ------------------------------------------------------------------
    // Scan datapath: one shared overlap tester, fed by the current channel
    // ------------------------------------------------------------------
    aabb_overlap #(
        .COORD_W (COORD_W),
        .A_W     (PLANE_W),
        .A_H     (PLANE_H),
        .B_W     (OBJ_W),
        .B_H     (OBJ_H)
    ) u_aabb_overlap (
        .i_a_x     (r_plane_x),
        .i_a_y     (r_plane_y),
        .i_b_x     (r_obj_x[r_idx]),
        .i_b_y     (r_obj_y[r_idx]),
        .o_overlap (w_overlap)
    );

    // Only the first valid hit is kept, which yields the lowest channel
    // index because channels are visited in ascending order.
    assign w_take_hit = (r_state == SCAN) & w_overlap & r_obj_valid[r_idx] & ~r_hit;

    assign busy = (r_state == SCAN);
    assign done = (r_state == DONE);

    // ------------------------------------------------------------------
    // Optional grace window after clear
    // ------------------------------------------------------------------
`ifdef CRASH_GRACE_EN
    localparam int                   c_grace_w = idx_width(GRACE_FRAMES + 1);
    localparam logic [c_grace_w-1:0] c_grace   = c_grace_w'(GRACE_FRAMES);

    logic [c_grace_w-1:0] r_grace_cnt;

    assign w_allow_game_over = (r_grace_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grace_cnt <= c_grace;
        end else if (clear) begin
            r_grace_cnt <= c_grace;
        end else if ((r_state == DONE) && (r_grace_cnt != '0)) begin
            r_grace_cnt <= r_grace_cnt - c_grace_w'(1);
        end
    end
`else
    logic w_unused_grace;

    assign w_unused_grace    = (GRACE_FRAMES != 0);
    assign w_allow_game_over = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. clear overrides everything, including a
    // simultaneous start.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_next = SCAN;
                    end
                end
                SCAN: begin
                    if (r_idx == c_last) begin
                        w_state_next = DONE;
                    end
                end
                DONE: begin
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_plane_x   <= '0;
            r_plane_y   <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_obj_x[i] <= '0;
                r_obj_y[i] <= '0;
            end
            r_obj_valid <= '0;
            r_idx       <= '0;
            r_hit       <= 1'b0;
            r_hit_idx   <= '0;
            crash       <= 1'b0;
            crash_idx   <= '0;
            game_over   <= 1'b0;
        end else if (clear) begin
            crash     <= 1'b0;
            game_over <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_plane_x   <= plane_x;
                        r_plane_y   <= plane_y;
                        for (int i = 0; i < NUM_OBJ; i++) begin
                            r_obj_x[i] <= obj_x[i*COORD_W +: COORD_W];
                            r_obj_y[i] <= obj_y[i*COORD_W +: COORD_W];
                        end
                        r_obj_valid <= obj_valid;
                        r_idx       <= '0;
                        r_hit       <= 1'b0;
                        r_hit_idx   <= '0;
                    end
                end
                SCAN: begin
                    if (w_take_hit) begin
                        r_hit     <= 1'b1;
                        r_hit_idx <= r_idx;
                    end
                    if (r_idx != c_last) begin
                        r_idx <= r_idx + c_idx_w'(1);
                    end
                end
                DONE: begin
                    crash     <= r_hit;
                    crash_idx <= r_hit_idx;
                    if (r_hit && w_allow_game_over) begin
                        game_over <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : collision_detector
`default_nettype wire

// File: tb/tb_collision_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collision_detector
//  Description : Directed self-checking bench for collision_detector using
//                the default geometry (4 channels, 10-bit coordinates,
//                8x8 plane, 16x16 obstacles) and GRACE_FRAMES = 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_detector;

    localparam int NUM_OBJ = 4;
    localparam int COORD_W = 10;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic                       clear;
    logic [COORD_W-1:0]         plane_x;
    logic [COORD_W-1:0]         plane_y;
    logic [NUM_OBJ*COORD_W-1:0] obj_x;
    logic [NUM_OBJ*COORD_W-1:0] obj_y;
    logic [NUM_OBJ-1:0]         obj_valid;
    logic                       busy;
    logic                       done;
    logic                       crash;
    logic [1:0]                 crash_idx;
    logic                       game_over;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    collision_detector #(
        .NUM_OBJ      (NUM_OBJ),
        .COORD_W      (COORD_W),
        .PLANE_W      (8),
        .PLANE_H      (8),
        .OBJ_W        (16),
        .OBJ_H        (16),
        .GRACE_FRAMES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .clear     (clear),
        .plane_x   (plane_x),
        .plane_y   (plane_y),
        .obj_x     (obj_x),
        .obj_y     (obj_y),
        .obj_valid (obj_valid),
        .busy      (busy),
        .done      (done),
        .crash     (crash),
        .crash_idx (crash_idx),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_obj(input int ch, input int x, input int y);
        logic [COORD_W-1:0] vx;
        logic [COORD_W-1:0] vy;
        vx = x[COORD_W-1:0];
        vy = y[COORD_W-1:0];
        obj_x[ch*COORD_W +: COORD_W] = vx;
        obj_y[ch*COORD_W +: COORD_W] = vy;
    endtask

    task automatic set_scene(input int px, input int py);
        plane_x = px[COORD_W-1:0];
        plane_y = py[COORD_W-1:0];
        obj_x   = '0;
        obj_y   = '0;
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        chk({tag, "_crash"}, crash, 0);
        chk({tag, "_game_over"}, game_over, 0);
    endtask

    // Pulses start (called at a negedge) and waits, with a cycle budget,
    // for done. With disturb set, start is held high while busy and the
    // live inputs are changed mid-scan; neither may affect the result.
    task automatic run_scan(input string tag, input bit disturb);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        start = 1'b1;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                start = disturb;
                chk({tag, "_busy"}, busy, 1);
            end
            if (disturb && n == 2) begin
                plane_x   = '0;
                plane_y   = '0;
                obj_valid = '0;
            end
            if (n == 3) start = 1'b0;
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_latency"}, n, NUM_OBJ + 1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_pulse_len"}, done, 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_done;

        reset     = 1'b1;
        start     = 1'b0;
        clear     = 1'b0;
        obj_valid = '0;
        set_scene(0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_crash", crash, 0);
        chk("rst_crash_idx", crash_idx, 0);
        chk("rst_game_over", game_over, 0);
        reset = 1'b0;
        @(negedge clk);

`ifdef CRASH_GRACE_EN
        // Grace window: two protected scans, then game_over on the third.
        do_clear("grace_clr");
        for (int s = 1; s <= 3; s++) begin
            set_scene(100, 100);
            set_obj(0, 104, 104);
            obj_valid = 4'b0001;
            run_scan("grace_scan", 1'b0);
            chk("grace_crash", crash, 1);
            chk("grace_game_over", game_over, (s == 3) ? 1 : 0);
        end
        do_clear("grace_end_clr");
`endif

        // Basic hit on channel 0, with live inputs disturbed mid-scan and
        // start held high while busy.
        set_scene(100, 100);
        set_obj(0, 104, 104);
        obj_valid = 4'b0001;
        run_scan("hit0", 1'b1);
        chk("hit0_crash", crash, 1);
        chk("hit0_idx", crash_idx, 0);
        chk("hit0_game_over", game_over, 1);
        do_clear("hit0_clr");

        // Right edge of plane touches left edge of obstacle: no crash.
        set_scene(100, 100);
        set_obj(2, 108, 100);
        obj_valid = 4'b0100;
        run_scan("touch", 1'b0);
        chk("touch_crash", crash, 0);
        chk("touch_game_over", game_over, 0);

        // Channels 1 and 3 overlap, channel 0 overlaps but is invalid:
        // lowest valid hit is 1.
        set_scene(100, 100);
        set_obj(0, 104, 104);
        set_obj(1, 96, 96);
        set_obj(3, 105, 103);
        obj_valid = 4'b1010;
        run_scan("multi", 1'b0);
        chk("multi_crash", crash, 1);
        chk("multi_idx", crash_idx, 1);
        chk("multi_game_over", game_over, 1);

        // All channels invalid: full-length scan, no crash, game_over sticks.
        obj_valid = 4'b0000;
        run_scan("clean", 1'b0);
        chk("clean_crash", crash, 0);
        chk("clean_idx", crash_idx, 0);
        chk("clean_game_over_sticky", game_over, 1);
        do_clear("clean_clr");

        // Screen-edge arithmetic: plane at x=1020 must not wrap onto x=2.
        set_scene(1020, 5);
        set_obj(0, 2, 5);
        obj_valid = 4'b0001;
        run_scan("wrap_far", 1'b0);
        chk("wrap_far_crash", crash, 0);

        // A real overlap right at the edge must still be detected.
        set_scene(1020, 5);
        set_obj(0, 1015, 5);
        obj_valid = 4'b0001;
        run_scan("wrap_near", 1'b0);
        chk("wrap_near_crash", crash, 1);
        chk("wrap_near_game_over", game_over, 1);
        do_clear("wrap_clr");

        // Abort: start, then clear during the scan.
        set_scene(100, 100);
        set_obj(0, 104, 104);
        obj_valid = 4'b0001;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);
        chk("abort_crash", crash, 0);
        chk("abort_game_over", game_over, 0);

        // clear and start together: clear wins, no scan starts.
        start = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        chk("clr_start_busy", busy, 0);
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("clr_start_no_done", saw_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_collision_detector
`default_nettype wire
